// File: rtl/hazard_ctrl_mc_pkg.sv
// hazard_ctrl_mc_pkg: shared types and indices for the hazard controller.
// Holds the multi-cycle unit state enum and unit/stage index constants.
package hazard_ctrl_mc_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    localparam int MC_LSU = 0;
    localparam int MC_DIV = 1;
    localparam int MC_CSR = 2;

    localparam int FWD_LSU = 0;
    localparam int FWD_WRB = 1;

endpackage

// File: rtl/hazard_ctrl_mc_tracker.sv
// mc_busy_tracker: busy/timeout FSM for one multi-cycle unit.
// Ports: clk, rst, req_i, ack_i, flush_i -> busy_o, busy_nx_o, timeout_o.
module mc_busy_tracker
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int MC_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    input  logic flush_i,
    output logic busy_o,
    output logic busy_nx_o,
    output logic timeout_o
);

    localparam int CW = (MC_TIMEOUT > 0) ? $clog2(MC_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

    mc_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        case (state_q)
            MC_IDLE: begin
                cnt_d = '0;
                if (req_i && !ack_i && !flush_i)
                    state_d = MC_BUSY;
            end
            MC_BUSY: begin
                if (ack_i) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else if (MC_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else if (flush_i) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    // saturates; only reachable with the timeout disabled
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o    = (state_q == MC_BUSY);
    // ack beats a same-cycle req
    assign busy_nx_o = ack_i ? 1'b0 : (req_i ? 1'b1 : busy_o);
    assign timeout_o = to_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: RAW forwarding select, multi-cycle stalls, flush/redirect.
// Ports: EXE sources, forwarding stage info, mc req/ack, redirects -> controls.
module hazard_ctrl_mc
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 2,
    parameter int NUM_MC     = 3,
    parameter int AW         = 5,
    parameter int MC_TIMEOUT = 256,
    localparam int SW        = $clog2(NUM_FWD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*AW-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]    src_use_i,
    input  logic [NUM_FWD*AW-1:0] fwd_rd_addr_i,
    input  logic [NUM_FWD-1:0]    fwd_rd_wr_i,
    input  logic [NUM_FWD-1:0]    fwd_late_i,
    input  logic [NUM_MC-1:0]     mc_req_i,
    input  logic [NUM_MC-1:0]     mc_ack_i,
    input  logic                  exe_new_pc_i,
    input  logic                  csr_new_pc_i,
    input  logic                  wfi_i,
    input  logic                  irq_flush_lsu_i,
    output logic [NUM_SRC*SW-1:0] fwd_sel_o,
    output logic                  stall_front_o,
    output logic                  stall_exe2lsu_o,
    output logic                  flush_front_o,
    output logic                  flush_exe2lsu_o,
    output logic                  flush_lsu2wrb_o,
    output logic                  if_exe_new_pc_o,
    output logic                  if_csr_new_pc_o,
    output logic                  if_wfi_o,
    output logic                  lsu_flush_o,
    output logic                  stall_q_o,
    output logic [NUM_MC-1:0]     mc_busy_o,
    output logic [NUM_MC-1:0]     mc_timeout_o
);

    logic [NUM_SRC-1:0] src_late;
    logic [NUM_MC-1:0]  busy_nx;
    logic               mc_stall;
    logic               late_hazard;
    logic               lsu_flush;
    logic               exe_acc;
    logic               stall_q_q;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic          hit;
        logic          lt;

        assign addr = src_addr_i[s*AW +: AW];

        // nearest stage wins; a late winner masks older copies
        always_comb begin
            sel = '0;
            hit = 1'b0;
            lt  = 1'b0;
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!hit && fwd_rd_wr_i[k] && addr != '0 &&
                    addr == fwd_rd_addr_i[k*AW +: AW]) begin
                    hit = 1'b1;
                    lt  = fwd_late_i[k];
                    sel = lt ? '0 : SW'(k + 1);
                end
            end
        end

        assign fwd_sel_o[s*SW +: SW] = sel;
        assign src_late[s]           = lt & src_use_i[s];
    end

    for (genvar u = 0; u < NUM_MC; u++) begin : g_mc
        mc_busy_tracker #(
            .MC_TIMEOUT (MC_TIMEOUT)
        ) u_trk (
            .clk       (clk),
            .rst       (rst),
            .req_i     (mc_req_i[u]),
            .ack_i     (mc_ack_i[u]),
            .flush_i   (lsu_flush),
            .busy_o    (mc_busy_o[u]),
            .busy_nx_o (busy_nx[u]),
            .timeout_o (mc_timeout_o[u])
        );
    end

    assign mc_stall    = |busy_nx;
    assign late_hazard = (|src_late) & ~mc_stall;
    assign lsu_flush   = csr_new_pc_i | wfi_i;
    assign exe_acc     = exe_new_pc_i & ~stall_front_o;

    assign stall_front_o   = late_hazard | mc_stall;
    assign stall_exe2lsu_o = mc_stall;
    assign flush_front_o   = exe_acc | lsu_flush;
    assign flush_exe2lsu_o = late_hazard | lsu_flush;
    assign flush_lsu2wrb_o = irq_flush_lsu_i;
    assign if_exe_new_pc_o = exe_acc & ~csr_new_pc_i;
    assign if_csr_new_pc_o = csr_new_pc_i;
    assign if_wfi_o        = wfi_i;
    assign lsu_flush_o     = lsu_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q_q <= 1'b0;
        else     stall_q_q <= mc_stall;
    end

    assign stall_q_o = stall_q_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed vectors with a queue-based scoreboard.
// The driver pushes expected output words; a negedge monitor pops and compares.
module tb_hazard_ctrl_mc;

    localparam int NS = 2, NF = 2, NM = 3, AW = 5, TO = 8;

    localparam logic [8:0] SF = 9'h100, SE = 9'h080, FF = 9'h040;
    localparam logic [8:0] FE = 9'h020, FL = 9'h010, IE = 9'h008;
    localparam logic [8:0] IC = 9'h004, IW = 9'h002, LF = 9'h001;

    logic            clk = 0, rst = 1;
    logic [2*AW-1:0] src_addr;
    logic [1:0]      src_use;
    logic [2*AW-1:0] fwd_addr;
    logic [1:0]      fwd_wr, fwd_late;
    logic [2:0]      req, ack;
    logic            exe_pc, csr_pc, wfi, irq;

    logic [3:0] fwd_sel;
    logic       sf, se, ff, fe, fl, ie, ic, iw, lf, sq;
    logic [2:0] busy, tmo;

    hazard_ctrl_mc #(
        .NUM_SRC(NS), .NUM_FWD(NF), .NUM_MC(NM), .AW(AW), .MC_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .src_addr_i(src_addr), .src_use_i(src_use),
        .fwd_rd_addr_i(fwd_addr), .fwd_rd_wr_i(fwd_wr), .fwd_late_i(fwd_late),
        .mc_req_i(req), .mc_ack_i(ack),
        .exe_new_pc_i(exe_pc), .csr_new_pc_i(csr_pc),
        .wfi_i(wfi), .irq_flush_lsu_i(irq),
        .fwd_sel_o(fwd_sel),
        .stall_front_o(sf), .stall_exe2lsu_o(se),
        .flush_front_o(ff), .flush_exe2lsu_o(fe), .flush_lsu2wrb_o(fl),
        .if_exe_new_pc_o(ie), .if_csr_new_pc_o(ic), .if_wfi_o(iw),
        .lsu_flush_o(lf), .stall_q_o(sq),
        .mc_busy_o(busy), .mc_timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t q[$];
    int   n_run = 0, n_fail = 0;

    function automatic logic [19:0] ex(input logic [3:0] fs, input logic [8:0] f,
                                       input logic s, input logic [2:0] b,
                                       input logic [2:0] t);
        return {fs, f, s, b, t};
    endfunction

    // monitor: every negedge with a pending expectation is one check
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [19:0] act;
            e   = q.pop_front();
            act = {fwd_sel, sf, se, ff, fe, fl, ie, ic, iw, lf, sq, busy, tmo};
            n_run++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", e.nm, act, e.v);
            end
        end
    end

    task automatic idle_in();
        src_addr = '0; src_use = '0; fwd_addr = '0; fwd_wr = '0;
        fwd_late = '0; req = '0; ack = '0;
        exe_pc = 0; csr_pc = 0; wfi = 0; irq = 0;
    endtask

    task automatic cyc(input string nm, input logic [19:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic fwd(input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] r0, input logic [4:0] r1);
        src_addr = {s1, s0};
        fwd_addr = {r1, r0};
    endtask

    initial begin
        idle_in();
        @(posedge clk);
        #1;
        cyc("reset", ex(4'b0, 9'h0, 0, 3'b0, 3'b0));
        rst = 0;

        fwd(5, 0, 5, 0); fwd_wr = 2'b01; src_use = 2'b01;
        cyc("fwd_stage0", ex(4'b0001, 9'h0, 0, 3'b0, 3'b0));
        fwd(5, 7, 7, 5); fwd_wr = 2'b11; src_use = 2'b11;
        cyc("fwd_stage1", ex(4'b0110, 9'h0, 0, 3'b0, 3'b0));
        fwd(5, 0, 5, 5); fwd_wr = 2'b11;
        cyc("fwd_nearest", ex(4'b0001, 9'h0, 0, 3'b0, 3'b0));
        fwd(5, 0, 5, 5); fwd_wr = 2'b10;
        cyc("fwd_wr_gate", ex(4'b0010, 9'h0, 0, 3'b0, 3'b0));
        fwd(5, 0, 5, 0); fwd_wr = 2'b01; fwd_late = 2'b01;
        src_use = 2'b01; exe_pc = 1;
        cyc("late_hazard", ex(4'b0000, SF | FE, 0, 3'b0, 3'b0));
        fwd(5, 0, 9, 5); fwd_wr = 2'b11; src_use = 2'b01;
        cyc("load_in_wrb", ex(4'b0010, 9'h0, 0, 3'b0, 3'b0));
        fwd(5, 0, 5, 5); fwd_wr = 2'b11; fwd_late = 2'b01;
        cyc("late_masks_unused", ex(4'b0000, 9'h0, 0, 3'b0, 3'b0));
        fwd(0, 0, 0, 0); fwd_wr = 2'b11; fwd_late = 2'b11; src_use = 2'b11;
        cyc("x0_no_match", ex(4'b0000, 9'h0, 0, 3'b0, 3'b0));
        exe_pc = 1;
        cyc("exe_redirect", ex(4'b0, FF | IE, 0, 3'b0, 3'b0));
        exe_pc = 1; csr_pc = 1;
        cyc("csr_prio", ex(4'b0, FF | FE | IC | LF, 0, 3'b0, 3'b0));
        wfi = 1; irq = 1;
        cyc("wfi_irq", ex(4'b0, FF | FE | FL | IW | LF, 0, 3'b0, 3'b0));

        req = 3'b010;
        cyc("div_req", ex(4'b0, SF | SE, 0, 3'b000, 3'b0));
        cyc("div_busy1", ex(4'b0, SF | SE, 1, 3'b010, 3'b0));
        fwd(5, 0, 5, 0); fwd_wr = 2'b01; fwd_late = 2'b01; src_use = 2'b01;
        cyc("div_busy2_late", ex(4'b0, SF | SE, 1, 3'b010, 3'b0));
        cyc("div_busy3", ex(4'b0, SF | SE, 1, 3'b010, 3'b0));
        ack = 3'b010;
        cyc("div_ack", ex(4'b0, 9'h0, 1, 3'b010, 3'b0));
        cyc("div_done", ex(4'b0, 9'h0, 0, 3'b000, 3'b0));

        req = 3'b001; ack = 3'b001;
        cyc("req_ack_same", ex(4'b0, 9'h0, 0, 3'b0, 3'b0));
        cyc("req_ack_after", ex(4'b0, 9'h0, 0, 3'b0, 3'b0));

        req = 3'b100;
        cyc("to_req", ex(4'b0, SF | SE, 0, 3'b000, 3'b0));
        for (int i = 1; i <= 8; i++)
            cyc($sformatf("to_busy%0d", i), ex(4'b0, SF | SE, 1, 3'b100, 3'b0));
        cyc("to_pulse", ex(4'b0, 9'h0, 1, 3'b000, 3'b100));
        cyc("to_after", ex(4'b0, 9'h0, 0, 3'b000, 3'b000));

        req = 3'b001;
        cyc("lsu_req", ex(4'b0, SF | SE, 0, 3'b000, 3'b0));
        cyc("lsu_busy", ex(4'b0, SF | SE, 1, 3'b001, 3'b0));
        exe_pc = 1; csr_pc = 1;
        cyc("flush_busy", ex(4'b0, SF | SE | FF | FE | IC | LF, 1, 3'b001, 3'b0));
        cyc("flush_cleared", ex(4'b0, 9'h0, 1, 3'b000, 3'b0));
        req = 3'b010; wfi = 1;
        cyc("flush_over_req", ex(4'b0, SF | SE | FF | FE | IW | LF, 0, 3'b0, 3'b0));
        cyc("flush_req_idle", ex(4'b0, 9'h0, 1, 3'b000, 3'b0));

        req = 3'b010;
        cyc("rst_req", ex(4'b0, SF | SE, 0, 3'b000, 3'b0));
        cyc("rst_busy", ex(4'b0, SF | SE, 1, 3'b010, 3'b0));
        #2 rst = 1;
        cyc("rst_mid", ex(4'b0, 9'h0, 0, 3'b000, 3'b0));
        rst = 0;
        cyc("rst_after", ex(4'b0, 9'h0, 0, 3'b000, 3'b0));

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
